// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Holds the controller state encoding, the RAM command opcodes and the default word width.
package ram_arb_pkg;

    localparam int ADDR_SIZE_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WDATA = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_RREAD = 2'b11;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin grant with an internal last-grant pointer.
// The pointer moves only when a grant is actually taken (update strobe).
module ram_arb_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic       grant,
    output logic       update
);

    logic last;

    always_comb begin
        // NOTE: the default assignment ahead of the case keeps this block purely combinational; a path that leaves grant unassigned would infer a latch.
        grant = ~last;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~last;
        endcase
    end

    assign update = en && (req != 2'b00);

    // Reset to "req1 granted last" so req0 wins the first contested cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (update) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin controller sharing a single-port RAM between two requesters.
// Optional read timeout in WAIT is enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic                 req0_rw,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [ADDR_SIZE-1:0] req0_wdata,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    output logic [ADDR_SIZE-1:0] rsp0_rdata,
    output logic                 rsp0_err,
    input  logic                 req1_valid,
    input  logic                 req1_rw,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [ADDR_SIZE-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    output logic [ADDR_SIZE-1:0] rsp1_rdata,
    output logic                 rsp1_err,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ram_arbiter: TIMEOUT must be in 1..255");
    end

    state_t               state;
    logic                 rw_q;
    logic                 owner_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [ADDR_SIZE-1:0] wdata_q;
    logic [ADDR_SIZE-1:0] rdata0_q;
    logic [ADDR_SIZE-1:0] rdata1_q;
    logic                 grant;
    logic                 accept;

    ram_arb_rr u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .en     (state == IDLE),
        .grant  (grant),
        .update (accept)
    );

    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) &&  grant && req1_valid;

`ifdef RAM_ARB_TIMEOUT_EN
    logic [7:0] cnt;
    logic       err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rw_q     <= 1'b0;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: if (accept) begin
                    state   <= ADDR;
                    owner_q <= grant;
                    rw_q    <= grant ? req1_rw    : req0_rw;
                    addr_q  <= grant ? req1_addr  : req0_addr;
                    wdata_q <= grant ? req1_wdata : req0_wdata;
`ifdef RAM_ARB_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                end
                ADDR: state <= DATA;
                DATA: begin
                    if (rw_q) begin
                        state <= WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end else begin
                        state <= RESP;
                        if (owner_q) rdata1_q <= '0;
                        else         rdata0_q <= '0;
                    end
                end
                // ram_tx_valid is only trusted here; elsewhere it may be stale.
                WAIT: begin
                    if (ram_tx_valid) begin
                        state <= RESP;
                        if (owner_q) rdata1_q <= ram_dout;
                        else         rdata0_q <= ram_dout;
                    end
`ifdef RAM_ARB_TIMEOUT_EN
                    else if (cnt == 8'(TIMEOUT - 1)) begin
                        state <= RESP;
                        err_q <= 1'b1;
                        if (owner_q) rdata1_q <= '0;
                        else         rdata0_q <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram_din      = '0;
        ram_rx_valid = 1'b0;
        case (state)
            ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {(rw_q ? CMD_RADDR : CMD_WADDR), addr_q};
            end
            DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = rw_q ? {CMD_RREAD, {ADDR_SIZE{1'b0}}} : {CMD_WDATA, wdata_q};
            end
            default: ;
        endcase
    end

    assign rsp0_valid = (state == RESP) && !owner_q;
    assign rsp1_valid = (state == RESP) &&  owner_q;
    assign rsp0_rdata = rdata0_q;
    assign rsp1_rdata = rdata1_q;

`ifdef RAM_ARB_TIMEOUT_EN
    assign rsp0_err = rsp0_valid && err_q;
    assign rsp1_err = rsp1_valid && err_q;
`else
    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and a reference memory model.
// Build with RAM_ARB_TIMEOUT_EN defined to exercise the read timeout path.
module tb_ram_arbiter;

    localparam int AS = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req0_rw = 1'b0;
    logic [AS-1:0] req0_addr = '0, req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_rw = 1'b0;
    logic [AS-1:0] req1_addr = '0, req1_wdata = '0;
    logic          req0_ready, rsp0_valid, rsp0_err;
    logic          req1_ready, rsp1_valid, rsp1_err;
    logic [AS-1:0] rsp0_rdata, rsp1_rdata;
    logic [AS+1:0] ram_din;
    logic          ram_rx_valid;
    logic [AS-1:0] ram_dout;
    logic          ram_tx_valid;

    int total = 0;
    int bad   = 0;

    ram_arbiter #(.ADDR_SIZE(AS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    // RAM: two-word command protocol; tx_valid held until the next command.
    logic [AS-1:0] mem [256] = '{default: 8'h00};
    logic [AS-1:0] ram_areg = '0;
    logic [AS-1:0] ram_rd = '0;
    logic          tx_reg = 1'b0;
    logic          suppress = 1'b0;
    logic          stale_hold = 1'b0;

    always @(posedge clk) begin
        if (ram_rx_valid) begin
            tx_reg <= 1'b0;
            case (ram_din[AS+1:AS])
                2'b00: ram_areg <= ram_din[AS-1:0];
                2'b01: mem[ram_areg] <= ram_din[AS-1:0];
                2'b10: ram_areg <= ram_din[AS-1:0];
                default: begin
                    ram_rd <= mem[ram_areg];
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ram_tx_valid = (tx_reg && !suppress) || stale_hold;
    assign ram_dout     = ram_rd;

    // Reference memory, updated when a write is granted.
    logic [AS-1:0] gold [256] = '{default: 8'h00};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int n);
        return (n != 0) ? req1_ready : req0_ready;
    endfunction
    function automatic logic rspv(input int n);
        return (n != 0) ? rsp1_valid : rsp0_valid;
    endfunction
    function automatic logic rspe(input int n);
        return (n != 0) ? rsp1_err : rsp0_err;
    endfunction
    function automatic logic [AS-1:0] rspd(input int n);
        return (n != 0) ? rsp1_rdata : rsp0_rdata;
    endfunction

    task automatic present(input int n, input logic rw, input logic [AS-1:0] a, input logic [AS-1:0] d);
        if (n == 0) begin
            req0_valid = 1'b1; req0_rw = rw; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_rw = rw; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic drop(input int n);
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    // Expects requester n to be granted in the current cycle and follows the transaction to completion.
    task automatic expect_xact(input int n, input logic rw, input logic [AS-1:0] a,
                               input logic [AS-1:0] d, input string tag);
        logic [AS-1:0] exp_rd;
        #1;
        check({tag, " ready"}, 32'(rdy(n)), 32'd1);
        check({tag, " other ready"}, 32'(rdy(1 - n)), 32'd0);
        if (!rw) gold[a] = d;
        exp_rd = rw ? gold[a] : '0;
        tick();
        drop(n);
        check({tag, " addr rx"}, 32'(ram_rx_valid), 32'd1);
        check({tag, " addr din"}, 32'(ram_din), 32'({(rw ? 2'b10 : 2'b00), a}));
        check({tag, " no early rsp"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
        tick();
        check({tag, " data din"}, 32'(ram_din), 32'(rw ? {2'b11, 8'h00} : {2'b01, d}));
        check({tag, " busy ready"}, 32'(req0_ready | req1_ready), 32'd0);
        if (rw) begin
            tick();
            check({tag, " wait quiet"}, 32'({ram_rx_valid, rsp0_valid, rsp1_valid}), 32'd0);
        end
        tick();
        check({tag, " rsp valid"}, 32'(rspv(n)), 32'd1);
        check({tag, " rsp other"}, 32'(rspv(1 - n)), 32'd0);
        check({tag, " rsp rdata"}, 32'(rspd(n)), 32'(exp_rd));
        check({tag, " rsp err"}, 32'(rspe(n)), 32'd0);
        check({tag, " resp din"}, 32'({ram_rx_valid, ram_din}), 32'd0);
        tick();
        check({tag, " rsp single"}, 32'(rspv(n)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          last;
        logic          pend [2];
        logic          prw  [2];
        logic [AS-1:0] pa   [2];
        logic [AS-1:0] pd   [2];
        int            g;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset rx", 32'(ram_rx_valid), 32'd0);
        check("reset din", 32'(ram_din), 32'd0);
        check("reset rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 32'd0);
        check("reset rdata", 32'({rsp0_rdata, rsp1_rdata}), 32'd0);
        check("reset ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed write then read-back from the other requester
        present(0, 1'b0, 8'h12, 8'hA5);
        expect_xact(0, 1'b0, 8'h12, 8'hA5, "wr0");
        present(1, 1'b1, 8'h12, 8'h00);
        expect_xact(1, 1'b1, 8'h12, 8'h00, "rd1");
        check("rd1 value", 32'(rsp1_rdata), 32'h0A5);
        last = 1'b1;

        // Both requesters continuously valid: alternation, nothing dropped
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r]) begin
                    prw[r] = 1'($urandom_range(1, 0));
                    pa[r]  = 8'($urandom_range(8'h1F, 8'h10));
                    pd[r]  = 8'($urandom);
                    present(r, prw[r], pa[r], pd[r]);
                    pend[r] = 1'b1;
                end
            end
            g = last ? 0 : 1;
            check("rr expected grant", 32'(g), 32'(k % 2));
            expect_xact(g, prw[g], pa[g], pd[g], "rr");
            pend[g] = 1'b0;
            last = 1'(g);
        end
        drop(0);
        drop(1);
        tick();

        // Stale tx_valid held across idle cycles and a write
        stale_hold = 1'b1;
        tick();
        check("stale idle", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        tick();
        present(1, 1'b0, 8'h33, 8'h5C);
        expect_xact(1, 1'b0, 8'h33, 8'h5C, "stale wr");
        stale_hold = 1'b0;
        tick();

        // Reset during a read's DATA cycle
        present(0, 1'b1, 8'h12, 8'h00);
        #1;
        check("rst rd ready", 32'(req0_ready), 32'd1);
        tick();
        drop(0);
        tick();
        check("rst rd in data", 32'(ram_din), 32'h300);
        rst_n = 1'b0;
        #1;
        check("rst now din", 32'({ram_rx_valid, ram_din}), 32'd0);
        check("rst now rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst no rsp", 32'({rsp0_valid, rsp1_valid, ram_rx_valid}), 32'd0);
        end
        // Pointer favours req0 again after reset
        present(0, 1'b1, 8'h33, 8'h00);
        present(1, 1'b1, 8'h12, 8'h00);
        expect_xact(0, 1'b1, 8'h33, 8'h00, "post rst0");
        expect_xact(1, 1'b1, 8'h12, 8'h00, "post rst1");

        // Read with tx_valid suppressed
        suppress = 1'b1;
        present(1, 1'b1, 8'h33, 8'h00);
        #1;
        check("sup ready", 32'(req1_ready), 32'd1);
        tick();
        drop(1);
        tick();
`ifdef RAM_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            tick();
            check("to wait", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        end
        tick();
        check("to rsp", 32'(rsp1_valid), 32'd1);
        check("to err", 32'(rsp1_err), 32'd1);
        check("to rdata", 32'(rsp1_rdata), 32'd0);
        suppress = 1'b0;
        tick();
        check("to done", 32'({rsp1_valid, rsp1_err}), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold wait", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        end
        suppress = 1'b0;
        tick();
        check("late rsp", 32'(rsp1_valid), 32'd1);
        check("late rdata", 32'(rsp1_rdata), 32'(gold[8'h33]));
        check("late err", 32'(rsp1_err), 32'd0);
        tick();
        check("late done", 32'(rsp1_valid), 32'd0);
`endif

        // Subsequent normal transaction after the long/timed-out read
        present(0, 1'b0, 8'h40, 8'h7E);
        expect_xact(0, 1'b0, 8'h40, 8'h7E, "after wr");
        present(0, 1'b1, 8'h40, 8'h00);
        expect_xact(0, 1'b1, 8'h40, 8'h00, "after rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
